counter_access_sched: RTL and testbench

Round-robin scheduler that shares one 3-bit loadable up-counter between two requesters. Each requester posts a load or increment; the block serialises them, drives the counter's ld/inc/data_in controls for exactly one cycle per transaction, returns the post-operation count, and refuses increments that would wrap 7→0. It sits between client logic and the counter instance, which it owns exclusively: no other driver of ld/inc.

---
 rtl/counter_access_sched.sv | 119 +++++++++++
 tb/tb_counter_access_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/counter_access_sched.sv
// Round-robin scheduler sharing one loadable up-counter between two requesters.
// Ports: clk/rst; req/op/data per requester in; gnt/done/rej/result out; cnt_* to counter; ovf_err, busy.
module counter_access_sched #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             rej,
  output logic [WIDTH-1:0] result,
  output logic             cnt_ld,
  output logic             cnt_inc,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             ovf_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             idx_q, idx_d;
  logic             op_q, op_d;
  logic             rej_q, rej_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic at_max;
  logic win;
  logic issue;
  logic in_done;

  assign at_max = (cnt_q == MAX);
  // Tie goes to whoever was not granted last; a lone request always wins.
  assign win = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      idx_q   <= 1'b0;
      op_q    <= 1'b0;
      rej_q   <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      rej_q   <= rej_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    op_d    = op_q;
    rej_d   = rej_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ISSUE;
          idx_d   = win;
          last_d  = win;
          op_d    = win ? op1 : op0;
          data_d  = win ? data1 : data0;
        end
      end
      ISSUE: begin
        rej_d = ~op_q & at_max;
        if (~op_q & at_max) ovf_d = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Strobes are suppressed while rst is high so an aborted issue never
    // touches the counter.
    issue    = (state_q == ISSUE) & ~rst;
    in_done  = (state_q == DONE);
    busy     = (state_q != IDLE);
    gnt0     = busy & ~idx_q;
    gnt1     = busy & idx_q;
    cnt_ld   = issue & op_q;
    cnt_inc  = issue & ~op_q & ~at_max;
    cnt_data = cnt_ld ? data_q : '0;
    done0    = in_done & ~idx_q;
    done1    = in_done & idx_q;
    rej      = in_done & rej_q;
    result   = in_done ? cnt_q : '0;
    ovf_err  = ovf_q;
  end

endmodule

// File: tb/tb_counter_access_sched.sv
// Directed bench for counter_access_sched with a behavioural 3-bit counter.
// Checks at #1 after each rising edge.
module tb_counter_access_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, op0, op1;
  logic [2:0] data0, data1;
  logic       gnt0, gnt1, done0, done1, rej;
  logic [2:0] result;
  logic       cnt_ld, cnt_inc;
  logic [2:0] cnt_data, cnt_q;
  logic       ovf_err, busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_access_sched #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .rej(rej), .result(result),
    .cnt_ld(cnt_ld), .cnt_inc(cnt_inc),
    .cnt_data(cnt_data), .cnt_q(cnt_q),
    .ovf_err(ovf_err), .busy(busy)
  );

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (cnt_ld) cnt_q <= cnt_data;
    else if (cnt_inc) cnt_q <= cnt_q + 3'd1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; data0 = 0; data1 = 0;
    tick; tick;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_strobe", {cnt_ld, cnt_inc}, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_result", result, 0);

    // load 5 by requester 0
    req0 = 1; op0 = 1; data0 = 3'd5;
    tick;
    chk("ld5_ld", cnt_ld, 1);
    chk("ld5_data", cnt_data, 5);
    chk("ld5_inc", cnt_inc, 0);
    chk("ld5_gnt", {gnt1, gnt0}, 2'b01);
    tick;
    chk("ld5_done", {done1, done0}, 2'b01);
    chk("ld5_result", result, 5);
    chk("ld5_rej", rej, 0);
    chk("ld5_data0", cnt_data, 0);
    req0 = 0;
    tick;
    chk("ld5_idle", busy, 0);

    // load 6, then two increments from requester 1
    req0 = 1; op0 = 1; data0 = 3'd6;
    tick; tick;
    req0 = 0;
    tick;
    req1 = 1; op1 = 0;
    tick;
    chk("inc1_inc", cnt_inc, 1);
    chk("inc1_gnt", {gnt1, gnt0}, 2'b10);
    tick;
    chk("inc1_done", {done1, done0}, 2'b10);
    chk("inc1_result", result, 7);
    chk("inc1_rej", rej, 0);
    chk("inc1_ovf", ovf_err, 0);
    tick;
    chk("inc2_idle", busy, 0);
    tick;
    chk("inc2_noinc", {cnt_ld, cnt_inc}, 0);
    tick;
    chk("inc2_done", done1, 1);
    chk("inc2_result", result, 7);
    chk("inc2_rej", rej, 1);
    chk("inc2_ovf", ovf_err, 1);
    req1 = 0;
    tick;
    chk("ovf_sticky", ovf_err, 1);
    chk("rej_clear", rej, 0);
    tick;
    chk("ovf_sticky2", ovf_err, 1);

    // reset, then both requesters increment continuously
    rst = 1;
    tick;
    rst = 0;
    chk("ovf_rst", ovf_err, 0);
    req0 = 1; op0 = 0; req1 = 1; op1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_gnt", {gnt1, gnt0}, (k % 2 == 0) ? 1 : 2);
      chk("rr_inc", cnt_inc, 1);
      tick;
      chk("rr_done", {done1, done0}, (k % 2 == 0) ? 1 : 2);
      chk("rr_result", result, k + 1);
      tick;
      chk("rr_idle", {busy, done1, done0}, 0);
    end
    req0 = 0; req1 = 0;
    tick;

    // last = 1, lone req1 wins at once
    req1 = 1; op1 = 0;
    tick;
    chk("lone1_gnt", {gnt1, gnt0}, 2'b10);
    tick;
    chk("lone1_done", done1, 1);
    chk("lone1_result", result, 5);
    req1 = 0;
    tick;

    // reset during issue of a load
    req0 = 1; op0 = 1; data0 = 3'd2;
    tick;
    chk("abort_ld_pre", cnt_ld, 1);
    rst = 1; req0 = 0;
    #1;
    chk("abort_no_strobe", cnt_ld, 0);
    tick;
    chk("abort_done", {done1, done0}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_gnt", {gnt1, gnt0}, 0);
    chk("abort_rej_res", {rej, result}, 0);
    chk("abort_cnt", cnt_q, 0);
    rst = 0;
    req0 = 1; op0 = 0; req1 = 1; op1 = 0;
    tick;
    chk("abort_tie", {gnt1, gnt0}, 2'b01);
    tick;
    chk("abort_tie_res", result, 1);
    req0 = 0; req1 = 0;
    tick;

    // op/data change after grant is ignored
    req0 = 1; op0 = 1; data0 = 3'd3;
    tick;
    op0 = 1; data0 = 3'd6;
    #1;
    chk("late_data", cnt_data, 3);
    op0 = 0;
    #1;
    chk("late_op", {cnt_ld, cnt_inc}, 2'b10);
    tick;
    chk("late_result", result, 3);
    chk("late_done", done0, 1);
    req0 = 0;
    tick;
    chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
